// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Types and constants shared by the CAN receive acceptance/buffering path.
//   CAN_ID_W / CAN_DATA_W : widths of the identifier and payload fields
//   FILT_IDX_W            : width of the accepting-filter index
//   can_frame_t           : one buffered frame {id, data, filt_idx}
//   AF_ACCEPT_ALL_BIT     : af_ctrl bit that bypasses all filters
//   AF_EN_LSB             : af_ctrl bit of filter slot 0 enable
// ---------------------------------------------------------------------------
package can_pkg;

    localparam int CAN_ID_W          = 32;
    localparam int CAN_DATA_W        = 64;
    localparam int FILT_IDX_W        = 3;
    localparam int AF_ACCEPT_ALL_BIT = 31;
    localparam int AF_EN_LSB         = 0;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   id;
        logic [CAN_DATA_W-1:0] data;
        logic [FILT_IDX_W-1:0] filt_idx;
    } can_frame_t;

endpackage

// File: rtl/can_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// can_rx_frame_fifo
// First-word-fall-through FIFO of can_frame_t with synchronous flush.
//   clk_can    : clock
//   rst_n      : asynchronous active-low reset (empties the FIFO, head = 0)
//   flush      : synchronous clear; overrides push and pop in that cycle
//   push       : write push_frame (dropped when full unless popping)
//   push_frame : frame to write
//   pop        : advance the head (ignored when empty)
//   head_frame : current head entry, registered
//   level      : entry count (wr_ptr - rd_ptr)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module can_rx_frame_fifo
    import can_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic       clk_can,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  can_frame_t push_frame,
    input  logic       pop,
    output can_frame_t head_frame,
    output logic [AW:0] level,
    output logic       full,
    output logic       empty
);

    can_frame_t  mem [0:FIFO_DEPTH-1];
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    can_frame_t  head_reg, head_next;
    logic        push_en, pop_en;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign pop_en  = pop & ~empty & ~flush;
    assign push_en = push & (~full | pop_en) & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        head_next   = head_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push_en) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_next = rd_ptr_reg + 1'b1;
            // The head register is loaded from the address the read pointer
            // will hold after this edge. When that slot is the one being
            // written right now, take the incoming frame directly.
            if (wr_ptr_next != rd_ptr_next) begin
                if (push_en && (rd_ptr_next == wr_ptr_reg))
                    head_next = push_frame;
                else
                    head_next = mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    // Storage array has no reset so it maps onto RAM.
    always_ff @(posedge clk_can) begin
        if (push_en)
            mem[wr_ptr_reg[AW-1:0]] <= push_frame;
    end

    always_ff @(posedge clk_can or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
        end
    end

    assign head_frame = head_reg;

endmodule

// File: rtl/can_rx_accept_fifo.sv
// ---------------------------------------------------------------------------
// can_rx_accept_fifo
// ID acceptance filter + frame FIFO between the CAN receive handler and the
// register front-end.
//   clk_can, rst_n         : clock, asynchronous active-low reset
//   af_ctrl                : [NUM_FILT-1:0] slot enables, [31] accept_all
//   filt_code / filt_mask  : per-slot code and mask (mask 1 = bit compared)
//   in_id/in_data/in_valid : received frame strobe
//   out_id/out_data/out_filt_idx/out_valid/out_ack : head frame, pop handshake
//   fifo_level             : entries buffered
//   overflow / ovf_clr     : sticky drop flag and its clear
//   rej_count              : saturating rejected-frame count
//   flush                  : synchronous pipeline and FIFO clear
// ---------------------------------------------------------------------------
module can_rx_accept_fifo
    import can_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_FILT   = 4,
    parameter int ID_W       = CAN_ID_W,
    parameter int DATA_W     = CAN_DATA_W
) (
    input  logic                         clk_can,
    input  logic                         rst_n,
    input  logic [31:0]                  af_ctrl,
    input  logic [NUM_FILT*ID_W-1:0]     filt_code,
    input  logic [NUM_FILT*ID_W-1:0]     filt_mask,
    input  logic [ID_W-1:0]              in_id,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic [ID_W-1:0]              out_id,
    output logic [DATA_W-1:0]            out_data,
    output logic [2:0]                   out_filt_idx,
    output logic                         out_valid,
    input  logic                         out_ack,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    input  logic                         ovf_clr,
    output logic [15:0]                  rej_count,
    input  logic                         flush
);

    logic [NUM_FILT-1:0] hit;
    logic [2:0]          win_idx;
    logic                accept;
    logic                s1_valid_reg, s1_valid_next;
    can_frame_t          s1_frame_reg, s1_frame_next;
    logic [15:0]         rej_count_reg, rej_count_next;
    logic                overflow_reg, overflow_next;
    logic                fifo_full, fifo_empty, ovf_set;
    can_frame_t          head_frame;
    logic                unused_af;

    // Bits of af_ctrl between the enables and accept_all carry no meaning.
    assign unused_af = ^af_ctrl;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FILT; gi++) begin : g_filt
            assign hit[gi] = af_ctrl[AF_EN_LSB + gi] &
                (((in_id ^ filt_code[gi*ID_W +: ID_W]) & filt_mask[gi*ID_W +: ID_W]) == '0);
        end
    endgenerate

    // Scan high-to-low so the lowest hitting slot is the last assignment.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_FILT - 1; i >= 0; i--) begin
            if (hit[i]) win_idx = 3'(i);
        end
    end

    assign accept = af_ctrl[AF_ACCEPT_ALL_BIT] | (|hit);

    always_comb begin
        s1_valid_next          = flush ? 1'b0 : (in_valid & accept);
        s1_frame_next          = '0;
        s1_frame_next.id       = CAN_ID_W'(in_id);
        s1_frame_next.data     = CAN_DATA_W'(in_data);
        s1_frame_next.filt_idx = win_idx;

        rej_count_next = rej_count_reg;
        if (in_valid && !accept && (rej_count_reg != 16'hFFFF))
            rej_count_next = rej_count_reg + 16'd1;

        // Dropping needs a full FIFO and no pop; a full FIFO is never empty,
        // so out_ack alone marks an effective pop here.
        ovf_set       = s1_valid_reg & fifo_full & ~out_ack & ~flush;
        overflow_next = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_reg);
    end

    always_ff @(posedge clk_can or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_frame_reg  <= '0;
            rej_count_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            s1_valid_reg  <= s1_valid_next;
            s1_frame_reg  <= s1_frame_next;
            rej_count_reg <= rej_count_next;
            overflow_reg  <= overflow_next;
        end
    end

    can_rx_frame_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_can    (clk_can),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (s1_valid_reg),
        .push_frame (s1_frame_reg),
        .pop        (out_ack),
        .head_frame (head_frame),
        .level      (fifo_level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign out_valid    = ~fifo_empty;
    assign out_id       = ID_W'(head_frame.id);
    assign out_data     = DATA_W'(head_frame.data);
    assign out_filt_idx = head_frame.filt_idx;
    assign overflow     = overflow_reg;
    assign rej_count    = rej_count_reg;

endmodule
